display_scan_ctrl: RTL
======================

Name: display_scan_ctrl

Overview:
Scan and brightness controller for the multiplexed 7-segment clock display. It time-shares the segment driver between NUM_DIGITS digit commons with a blanking dead-time at the start of every digit slot. It gates each digit enable with the PWM output of the LED duty-cycle generator. It also slews the 3-bit brightness level fed to that generator toward a target, one step per FADE_FRAMES scan frames, so brightness changes fade instead of jumping.

Parameters:
NUM_DIGITS, 6, number of digit commons scanned (2..8)
DIGIT_TICKS, 4000, clk cycles per digit slot, blank plus drive (> BLANK_TICKS)
BLANK_TICKS, 200, dead-time clk cycles at the start of each slot (>= 1)
FADE_FRAMES, 8, full scan frames per brightness step (>= 1)
LEVEL_MAX, 4, highest legal brightness level (constant-on)
RESET_LEVEL, 2, brightness value after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = scan display; 0 = all digits off
target_level  in  3  requested brightness; values > LEVEL_MAX are clamped to LEVEL_MAX
level_load  in  1  1-cycle pulse: jump brightness to clamped target immediately
pwm_on  in  1  duty-cycle output from the LED PWM generator
brightness  out  3  current level, drives the PWM generator brightness input
digit_en  out  NUM_DIGITS  one-hot digit common enables, active-high
digit_idx  out  3  index of the digit slot currently active (segment data select)
frame_start  out  1  1-cycle pulse on the first BLANK cycle of digit 0
fading  out  1  1 while brightness != clamped target_level

Behaviour:
- Reset (sync, high) sets: state IDLE, tick_cnt 0, digit_idx 0, frame_start 0, fade_cnt 0, brightness RESET_LEVEL. Reset has priority over every other input.
- States: IDLE, BLANK, DRIVE. tick_cnt has width $clog2(DIGIT_TICKS) and counts clk cycles within a slot.
- IDLE: digit_idx held at 0. If enable=1, the next state is BLANK with tick_cnt=0, and frame_start=1 in that first BLANK cycle.
- BLANK: lasts BLANK_TICKS cycles. When tick_cnt==BLANK_TICKS-1, go to DRIVE.
- DRIVE: lasts DIGIT_TICKS-BLANK_TICKS cycles. When tick_cnt==DIGIT_TICKS-1, go to BLANK and reset tick_cnt to 0.
  - digit_idx increments and wraps NUM_DIGITS-1 -> 0.
  - On the wrap, frame_start=1 for the first BLANK cycle.
- enable=0 in any state: the next cycle is IDLE, with tick_cnt=0 and digit_idx=0. An active slot is aborted with no completion. Re-enable always restarts at digit 0 BLANK.
- digit_en is combinational from registered state plus pwm_on: onehot(digit_idx) when state==DRIVE && pwm_on, else all 0. It is never asserted in BLANK or IDLE, and never more than one bit.
- frame_start is registered, at most one cycle per frame, and is 0 in IDLE.
- Target clamp: tgt = (target_level > LEVEL_MAX) ? LEVEL_MAX : target_level. The clamp is combinational and also used for fading.
- Fade stepping:
  - On each frame_start with brightness != tgt: if fade_cnt == FADE_FRAMES-1, brightness moves one step toward tgt (±1) and fade_cnt becomes 0; otherwise fade_cnt increments.
  - With brightness == tgt, fade_cnt is held at 0.
  - A target change mid-fade keeps the current fade_cnt. Direction is re-evaluated at each step.
- level_load=1: next cycle brightness = tgt and fade_cnt = 0. This takes priority over a coincident fade step, and works in any state including IDLE.
- While disabled there is no frame_start, so brightness is frozen except via level_load.
- brightness never leaves 0..LEVEL_MAX. Steps never overshoot tgt.

Test Plan:
Bench parameters: NUM_DIGITS=3, DIGIT_TICKS=10, BLANK_TICKS=2, FADE_FRAMES=2.
1. Reset, then enable=1, pwm_on=1 held -> from the cycle after enable:
   - digit_en=000 for 2 cycles, 001 for 8, 000 for 2, 010 for 8, 000 for 2, 100 for 8, repeating.
   - frame_start pulses every 30 cycles, on the first cycle.
   - digit_idx steps 0,1,2,0.
2. Scanning with pwm_on toggling every cycle -> digit_en follows pwm_on only in DRIVE, always 000 in BLANK. Never two bits set.
3. brightness=2 after reset, target_level=4, enable=1 -> fading=1; brightness=3 at the 2nd frame_start, 4 at the 4th; then fading=0 and brightness stays 4.
4. target_level=7 -> treated as 4 (fading resolves at 4). Then target_level=0 with a level_load pulse -> brightness=0 the next cycle, fade_cnt=0, fading=0.
5. enable dropped at digit 1, DRIVE tick 5 -> next cycle digit_en=000 and digit_idx=0 (IDLE). Re-enable -> BLANK of digit 0 with frame_start=1.
6. reset asserted mid-fade during DRIVE -> next cycle brightness=2, digit_en=000, digit_idx=0, fade_cnt=0, frame_start=0.

Source files
------------

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : display_scan_ctrl
//  Purpose  : Multiplexed 7-segment scan controller with per-slot blanking,
//             PWM-gated digit enables and slewed brightness level.
//  Revision : 1.0  initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int NUM_DIGITS  = 6,
    parameter int DIGIT_TICKS = 4000,
    parameter int BLANK_TICKS = 200,
    parameter int FADE_FRAMES = 8,
    parameter int LEVEL_MAX   = 4,
    parameter int RESET_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2:0]            target_level,
    input  logic                  level_load,
    input  logic                  pwm_on,
    output logic [2:0]            brightness,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [2:0]            digit_idx,
    output logic                  frame_start,
    output logic                  fading
);

    localparam int c_tick_w = $clog2(DIGIT_TICKS);
    localparam int c_fade_w = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [c_tick_w-1:0]   tick_cnt_q, tick_cnt_d;
    logic [2:0]            digit_idx_q, digit_idx_d;
    logic                  frame_start_q, frame_start_d;
    logic [c_fade_w-1:0]   fade_cnt_q, fade_cnt_d;
    logic [2:0]            brightness_q, brightness_d;
    logic [2:0]            w_tgt;

    // Clamp the requested level; shared by load, fade stepping and fading flag.
    always_comb begin
        w_tgt = (target_level > 3'(LEVEL_MAX)) ? 3'(LEVEL_MAX) : target_level;
    end

    // Scan sequencer: slot timing, digit rotation and frame marker.
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        digit_idx_d   = digit_idx_q;
        frame_start_d = 1'b0;
        if (!enable) begin
            // Disabling aborts any slot; restart always begins at digit 0.
            state_d     = IDLE;
            tick_cnt_d  = '0;
            digit_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d       = BLANK;
                    tick_cnt_d    = '0;
                    digit_idx_d   = '0;
                    frame_start_d = 1'b1;
                end
                BLANK: begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == c_tick_w'(BLANK_TICKS - 1)) begin
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (tick_cnt_q == c_tick_w'(DIGIT_TICKS - 1)) begin
                        state_d    = BLANK;
                        tick_cnt_d = '0;
                        if (digit_idx_q == 3'(NUM_DIGITS - 1)) begin
                            digit_idx_d   = '0;
                            frame_start_d = 1'b1;
                        end else begin
                            digit_idx_d = digit_idx_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    tick_cnt_d  = '0;
                    digit_idx_d = '0;
                end
            endcase
        end
    end

    // Brightness slew: one step per FADE_FRAMES frames, load jumps immediately.
    always_comb begin
        brightness_d = brightness_q;
        fade_cnt_d   = fade_cnt_q;
        if (level_load) begin
            brightness_d = w_tgt;
            fade_cnt_d   = '0;
        end else if (brightness_q == w_tgt) begin
            fade_cnt_d = '0;
        end else if (frame_start_q) begin
            if (fade_cnt_q == c_fade_w'(FADE_FRAMES - 1)) begin
                fade_cnt_d   = '0;
                // Direction re-evaluated every step so a retarget never overshoots.
                brightness_d = (brightness_q > w_tgt) ? brightness_q - 1'b1
                                                      : brightness_q + 1'b1;
            end else begin
                fade_cnt_d = fade_cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            digit_idx_q   <= '0;
            frame_start_q <= 1'b0;
            fade_cnt_q    <= '0;
            brightness_q  <= 3'(RESET_LEVEL);
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            digit_idx_q   <= digit_idx_d;
            frame_start_q <= frame_start_d;
            fade_cnt_q    <= fade_cnt_d;
            brightness_q  <= brightness_d;
        end
    end

    // Digit commons only light during DRIVE and only while the PWM is on.
    always_comb begin
        digit_en = '0;
        if (state_q == DRIVE && pwm_on) begin
            digit_en = NUM_DIGITS'(1) << digit_idx_q;
        end
    end

    assign brightness  = brightness_q;
    assign digit_idx   = digit_idx_q;
    assign frame_start = frame_start_q;
    assign fading      = (brightness_q != w_tgt);

endmodule
`default_nettype wire
